sdram_frame_writer: RTL

Avalon-MM write master that drains a rendered pixel stream into the SDR SDRAM controller slave of the `system` Qsys design (16-bit data, 25-bit word address). It is the initiator end of that slave port: it accepts RGB565 pixels over a valid/ready stream, buffers them in a small FIFO, and issues single-word writes to a linear frame buffer at a programmable base address. It fully respects `avm_waitrequest` and reports completion of each frame.

---
 rtl/sdram_frame_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: Avalon-MM write master that drains an RGB565 pixel
// stream into a linear frame buffer, one 16-bit word per write.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; no pixels accepted, bus idle
// S_RUN  | accepting pixels into the FIFO and issuing writes
// S_DONE | final write completed; done pulses for this single cycle
module sdram_frame_writer #(
  parameter int ADDR_W     = 25,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_idx;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    fifo_cnt;

  logic start_ok;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic wr_cmpl;
  logic last_cmpl;

  // Handshake qualifiers shared by the FIFO, the counters and the bus register.
  always_comb begin
    start_ok   = (state == S_IDLE) && start;
    fifo_full  = (fifo_cnt == DEPTH_C);
    fifo_empty = (fifo_cnt == '0);
    in_ready   = (state == S_RUN) && !fifo_full && (acc_cnt < TOTAL_C);
    push       = in_valid && in_ready;
    wr_cmpl    = avm_write && !avm_waitrequest;
    last_cmpl  = wr_cmpl && (wr_cnt == LAST_IDX);
    // A new word is loaded when the bus is free, or back-to-back when the
    // current word completes and it was not the last word of the frame.
    pop        = (state == S_RUN) && !fifo_empty &&
                 (!avm_write || (wr_cmpl && !last_cmpl));
    // Index of the word being loaded: the completing word already counts.
    wr_idx     = wr_cmpl ? (wr_cnt + CNT_W'(1)) : wr_cnt;
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_cmpl) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; a new frame discards anything left over.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start_ok) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Frame base and the accepted / written pixel counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      base_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (start_ok) begin
      base_q  <= base_addr;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push)    acc_cnt <= acc_cnt + CNT_W'(1);
      if (wr_cmpl) wr_cnt  <= wr_cnt + CNT_W'(1);
    end
  end

  // Registered bus request; everything holds while the slave stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= 2'b00;
    end else if (pop) begin
      avm_write      <= 1'b1;
      avm_address    <= base_q + ADDR_W'(wr_idx);
      avm_writedata  <= fifo_mem[rd_ptr];
      avm_byteenable <= 2'b11;
    end else if (wr_cmpl) begin
      avm_write      <= 1'b0;
      avm_byteenable <= 2'b00;
    end
  end

endmodule
